// File: rtl/uart_rx_param_if.sv
// Frame delivery handshake between the UART receiver and its consumer.
// Master side produces frames, slave side accepts them with rx_ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready delivery.
// Define UART_RX_PARAM_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVS_FACTOR  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_ovs,
    input  logic       rx_pin,
    input  logic [1:0] parity_mode,
    input  logic       stop_bits2,
    output logic       busy,
    uart_rx_param_if.master rx_if
);
    localparam int OW = $clog2(OVS_FACTOR);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [OW-1:0] OS_MID = OW'(OVS_FACTOR / 2);
    localparam logic [OW-1:0] OS_END = OW'(OVS_FACTOR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    state_t               state;
    logic [OW-1:0]        os_count;
    logic [BW-1:0]        bit_index;
    logic [DATA_BITS-1:0] shift;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rxs;
    logic                 sample;
    logic                 par_en;
    logic                 par_odd;
    logic                 stop2;
    logic                 stop_second;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 frame_done;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARAM_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous tick samples for the majority vote.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist <= 2'b11;
        end else if (tick_ovs) begin
            hist <= {hist[0], rxs};
        end
    end

    assign sample = (hist[1] & hist[0]) |
                    (hist[1] & rxs) |
                    (hist[0] & rxs);
`else
    assign sample = rxs;
`endif

    // Frame FSM: advances on oversampling ticks, pulses frame_done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            os_count    <= '0;
            bit_index   <= '0;
            shift       <= '0;
            par_en      <= 1'b0;
            par_odd     <= 1'b0;
            stop2       <= 1'b0;
            stop_second <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick_ovs) begin
                unique case (state)
                    IDLE: begin
                        os_count <= '0;
                        if (!rxs) begin
                            state       <= START;
                            par_en      <= (parity_mode == 2'b01) ||
                                           (parity_mode == 2'b10);
                            par_odd     <= (parity_mode == 2'b01);
                            stop2       <= stop_bits2;
                            stop_second <= 1'b0;
                            perr_q      <= 1'b0;
                            ferr_q      <= 1'b0;
                        end
                    end
                    START: begin
                        if (os_count == OS_MID) begin
                            os_count  <= '0;
                            bit_index <= '0;
                            state     <= sample ? IDLE : DATA;
                        end else begin
                            os_count <= os_count + 1'b1;
                        end
                    end
                    DATA: begin
                        if (os_count == OS_END) begin
                            os_count  <= '0;
                            shift     <= {sample, shift[DATA_BITS-1:1]};
                            bit_index <= bit_index + 1'b1;
                            if (bit_index == BIT_LAST) begin
                                state <= par_en ? PARITY : STOP;
                            end
                        end else begin
                            os_count <= os_count + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (os_count == OS_END) begin
                            os_count <= '0;
                            perr_q   <= (^{shift, sample}) != par_odd;
                            state    <= STOP;
                        end else begin
                            os_count <= os_count + 1'b1;
                        end
                    end
                    STOP: begin
                        if (os_count == OS_END) begin
                            os_count <= '0;
                            if (!sample) begin
                                ferr_q <= 1'b1;
                            end
                            if (stop2 && !stop_second) begin
                                stop_second <= 1'b1;
                            end else begin
                                frame_done <= 1'b1;
                                state      <= sample ? IDLE : BRK_WAIT;
                            end
                        end else begin
                            os_count <= os_count + 1'b1;
                        end
                    end
                    BRK_WAIT: begin
                        os_count <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        os_count <= '0;
                    end
                endcase
            end
        end
    end

    // Deliver completed frames, handle consumer handshake and overrun.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_if.rx_data     <= '0;
            rx_if.rx_valid    <= 1'b0;
            rx_if.parity_err  <= 1'b0;
            rx_if.frame_err   <= 1'b0;
            rx_if.overrun_err <= 1'b0;
            busy              <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid    <= 1'b0;
                rx_if.overrun_err <= 1'b0;
            end
            if (frame_done) begin
                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                    rx_if.rx_data    <= shift;
                    rx_if.parity_err <= perr_q;
                    rx_if.frame_err  <= ferr_q;
                    rx_if.rx_valid   <= 1'b1;
                end else begin
                    rx_if.overrun_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (8 data bits, OVS 16, tick every 4 clk).
// Frames are driven slot by slot; a monitor checks each accepted frame.
`timescale 1ns/1ps
module tb_uart_rx_param;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_ovs = 1'b0;
    logic       rx_pin = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       stop_bits2 = 1'b0;
    logic       busy;
    logic [1:0] tcnt = 2'd0;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];

    uart_rx_param_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_param #(
        .DATA_BITS(8),
        .OVS_FACTOR(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tick_ovs(tick_ovs),
        .rx_pin(rx_pin),
        .parity_mode(parity_mode),
        .stop_bits2(stop_bits2),
        .busy(busy),
        .rx_if(rx_if)
    );

    always #5 clk = ~clk;

    // One tick_ovs pulse every four clocks.
    always @(posedge clk) begin
        tcnt     <= tcnt + 2'd1;
        tick_ovs <= (tcnt == 2'd3);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every accepted frame.
    always @(negedge clk) begin
        if (reset_n && rx_if.rx_valid && rx_if.rx_ready) begin
            automatic logic have = (q.size() != 0);
            automatic exp_t e;
            chk("frame_expected", 32'(have), 32'd1);
            if (have) begin
                e = q.pop_front();
                chk("rx_data", 32'(rx_if.rx_data), 32'(e.d));
                chk("parity_err", 32'(rx_if.parity_err), 32'(e.pe));
                chk("frame_err", 32'(rx_if.frame_err), 32'(e.fe));
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (tick_ovs !== 1'b1);
        #1;
    endtask

    task automatic send_bit(input logic v, input int gslot);
        for (int s = 1; s <= 16; s++) begin
            rx_pin = (s == gslot) ? ~v : v;
            wait_tick();
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input int par,
                              input int gbit, input int gslot);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], (i == gbit) ? gslot : 0);
        end
        if (par >= 0) send_bit(par[0], 0);
        send_bit(1'b1, 0);
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        q.push_back(e);
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rx_if.rx_valid), 32'd0);
        chk("rst_data", 32'(rx_if.rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(rx_if.overrun_err), 32'd0);
        reset_n = 1'b1;
        wait_tick();
        idle_bits(2);

        // 8N1 back-to-back
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, -1, -1, 0);
        push(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, -1, -1, 0);
        idle_bits(1);

        // parity: 0x3C has even weight, parity bit 1
        parity_mode = 2'b10;
        push(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1, -1, 0);
        parity_mode = 2'b01;
        push(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1, -1, 0);
        parity_mode = 2'b00;
        idle_bits(1);

        // break: 20 bit times low
        push(8'h00, 1'b0, 1'b1);
        rx_pin = 1'b0;
        repeat (320) wait_tick();
        rx_pin = 1'b1;
        idle_bits(3);

        // false start: 3-tick low pulse
        rx_pin = 1'b0;
        repeat (3) wait_tick();
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        rx_pin = 1'b1;
        repeat (32) wait_tick();
        chk("glitch_busy_lo", 32'(busy), 32'd0);

        // single-tick glitch inside data bit 3
`ifdef UART_RX_PARAM_MAJORITY_EN
        push(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, -1, 3, 9);
`else
        push(8'h08, 1'b0, 1'b0);
        send_frame(8'h00, -1, 3, 10);
`endif
        idle_bits(1);

        // overrun
        rx_if.rx_ready = 1'b0;
        push(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, -1, -1, 0);
        send_frame(8'h22, -1, -1, 0);
        chk("ovr_valid", 32'(rx_if.rx_valid), 32'd1);
        chk("ovr_data", 32'(rx_if.rx_data), 32'h11);
        chk("ovr_flag", 32'(rx_if.overrun_err), 32'd1);
        rx_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b0;
        chk("ovr_valid_clr", 32'(rx_if.rx_valid), 32'd0);
        chk("ovr_flag_clr", 32'(rx_if.overrun_err), 32'd0);
        rx_if.rx_ready = 1'b1;
        wait_tick();
        idle_bits(1);

        // reset during bit 4
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        rx_pin = 1'b1;
        repeat (5) wait_tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("mid_rst_out", {25'd0, busy, rx_if.rx_valid,
                            rx_if.parity_err, rx_if.frame_err,
                            rx_if.overrun_err, 2'b00}, 32'd0);
        chk("mid_rst_data", 32'(rx_if.rx_data), 32'd0);
        wait_tick();
        idle_bits(2);
        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, -1, -1, 0);
        idle_bits(1);

        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
